// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core constants used by the fetch stage
package riscv_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] NOP_INS      = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - memory, redirect and decode handshake bundle of the fetch queue
interface if_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] i_addr;
    logic            ce;
    logic [XLEN-1:0] i_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_ins;
    logic [CW-1:0]   count;

    modport master (
        output i_addr, ce, id_valid, id_pc, id_ins, count,
        input  i_data, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  i_addr, ce, id_valid, id_pc, id_ins, count,
        output i_data, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding {pc, instruction} prefetch entries
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_W);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && rst_n && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Flush shares the reset path: a redirect discards everything queued.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch control feeding a prefetch queue toward decode
module if_fetch_queue
    import riscv_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic             clk,
    input  logic             rst_n,
    if_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   inflight_pc;
    logic              inflight;
    logic              kill;
    logic              ce_int;
    logic [CW:0]       occupancy;

    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [2*XLEN-1:0] fifo_head;

    // A redirect kills the response arriving this cycle; ce is already held
    // low in the redirect cycle, so no response is outstanding afterward.
    assign kill = bus.redirect_valid;

    // Reserve a slot for the in-flight response so a full queue never drops data.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign ce_int    = rst_n && !bus.redirect_valid && (occupancy < DEPTH_W);

    assign bus.ce     = ce_int;
    assign bus.i_addr = fetch_pc;
    assign fifo_push  = inflight && !kill && !fifo_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= ce_int;
            if (ce_int) begin
                fetch_pc    <= fetch_pc + XLEN'(4);
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (fifo_push),
        .wdata ({inflight_pc, bus.i_data}),
        .pop   (bus.id_ready),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // An empty queue presents a NOP so decode never sees stale data.
    assign bus.id_valid = !fifo_empty;
    assign bus.id_pc    = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];
    assign bus.id_ins   = fifo_empty ? XLEN'(NOP_INS) : fifo_head[XLEN-1:0];
    assign bus.count    = fifo_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed self-checking bench for if_fetch_queue
module tb_if_fetch_queue;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    if_fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();
    if_fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus_hi ();

    if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_hi)
    );

    always @(posedge clk) if (bus.ce)    bus.i_data    <= bus.i_addr ^ 32'hA5A5_0000;
    always @(posedge clk) if (bus_hi.ce) bus_hi.i_data <= bus_hi.i_addr ^ 32'hA5A5_0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        bus_hi.redirect_valid = 1'b0;
        bus_hi.redirect_pc    = '0;
        bus_hi.id_ready       = 1'b1;
        tick();
        tick();

        check("rst_ce",       bus.ce,       0);
        check("rst_id_valid", bus.id_valid, 0);
        check("rst_id_pc",    bus.id_pc,    0);
        check("rst_id_ins",   bus.id_ins,   64'h13);
        check("rst_count",    bus.count,    0);
        check("rst_i_addr",   bus.i_addr,   0);
        check("rst_hi_addr",  bus_hi.i_addr, 64'hFFFF_FFF8);

        // free run, 1 instruction per cycle
        bus.id_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("run_c1_ce",    bus.ce,     1);
        check("run_c1_addr",  bus.i_addr, 0);
        tick();
        check("run_c2_valid", bus.id_valid, 0);
        tick();
        check("run_c3_valid", bus.id_valid, 1);
        check("run_c3_pc",    bus.id_pc,    0);
        check("run_c3_ins",   bus.id_ins,   64'hA5A5_0000);
        check("hi_c3_pc",     bus_hi.id_pc, 64'hFFFF_FFF8);
        check("hi_c3_ins",    bus_hi.id_ins, 64'h5A5A_FFF8);
        tick();
        check("run_c4_pc",    bus.id_pc,    64'h4);
        check("run_c4_ins",   bus.id_ins,   64'hA5A5_0004);
        check("hi_c4_pc",     bus_hi.id_pc, 64'hFFFF_FFFC);
        tick();
        check("run_c5_pc",    bus.id_pc,    64'h8);
        check("hi_c5_pc",     bus_hi.id_pc, 64'h0);
        check("hi_c5_ins",    bus_hi.id_ins, 64'hA5A5_0000);
        tick();
        check("run_c6_pc",    bus.id_pc,    64'hC);
        check("run_c6_ins",   bus.id_ins,   64'hA5A5_000C);
        check("run_c6_count", bus.count,    1);

        // backpressure until full, then drain
        rst_n = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        repeat (10) tick();
        check("full_count",   bus.count,  4);
        check("full_ce",      bus.ce,     0);
        check("full_addr",    bus.i_addr, 64'h10);
        check("full_head",    bus.id_pc,  0);
        bus.id_ready = 1'b1;
        #1;
        check("drain_pc0",    bus.id_pc,  0);
        check("drain_ce0",    bus.ce,     0);
        tick();
        check("drain_pc4",    bus.id_pc,  64'h4);
        check("drain_ce1",    bus.ce,     1);
        tick();
        check("drain_pc8",    bus.id_pc,  64'h8);
        tick();
        check("drain_pcC",    bus.id_pc,  64'hC);
        tick();
        check("drain_pc10",   bus.id_pc,  64'h10);
        check("drain_ins10",  bus.id_ins, 64'hA5A5_0010);

        // redirect with 3 queued and 1 in flight
        rst_n = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        repeat (4) tick();
        check("redir_pre_count", bus.count, 3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0102;
        #1;
        check("redir_ce_held", bus.ce, 0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("redir_count",  bus.count,    0);
        check("redir_valid",  bus.id_valid, 0);
        check("redir_addr",   bus.i_addr,   64'h100);
        check("redir_ce",     bus.ce,       1);
        tick();
        check("redir_killed", bus.id_valid, 0);
        tick();
        check("redir_tgt_valid", bus.id_valid, 1);
        check("redir_tgt_pc",    bus.id_pc,    64'h100);
        check("redir_tgt_ins",   bus.id_ins,   64'hA5A5_0100);

        // redirect coincident with pop of pc=8
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.id_ready = 1'b1;
        #1;
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        #1;
        check("pop_redir_pc8", bus.id_pc, 64'h8);
        check("pop_redir_ce",  bus.ce,    0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("pop_redir_valid1", bus.id_valid, 0);
        check("pop_redir_addr",   bus.i_addr,   64'h200);
        tick();
        check("pop_redir_valid2", bus.id_valid, 0);
        tick();
        check("pop_redir_next_pc", bus.id_pc,    64'h200);
        check("pop_redir_next_v",  bus.id_valid, 1);

        // reset mid-operation with count=2 and a response in flight
        rst_n = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        repeat (3) tick();
        check("mid_pre_count", bus.count, 2);
        rst_n = 1'b0;
        #1;
        check("mid_ce_low", bus.ce, 0);
        tick();
        check("mid_count",  bus.count,    0);
        check("mid_valid",  bus.id_valid, 0);
        check("mid_pc",     bus.id_pc,    0);
        check("mid_ins",    bus.id_ins,   64'h13);
        check("mid_addr",   bus.i_addr,   0);
        rst_n = 1'b1;
        #1;
        check("mid_c1_ce",  bus.ce, 1);
        tick();
        check("mid_c2_count", bus.count,    0);
        check("mid_c2_valid", bus.id_valid, 0);
        tick();
        check("mid_c3_pc",    bus.id_pc,  0);
        check("mid_c3_ins",   bus.id_ins, 64'hA5A5_0000);
        check("mid_c3_count", bus.count,  1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_addr  output  XLEN  instruction memory address.
REQ-007 SHALL have port ce  output  1  instruction memory read enable.
REQ-008 SHALL have port i_data  input  XLEN  memory read data, valid exactly 1 cycle after ce=1.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump taken, from MEM stage.
REQ-010 SHALL have port redirect_pc  input  XLEN  branch target.
REQ-011 SHALL have port id_ready  input  1  ID accepts the head instruction this cycle (deasserted on pc_stop).
REQ-012 SHALL have port id_valid  output  1  head entry valid.
REQ-013 SHALL have port id_pc  output  XLEN  PC of head entry.
REQ-014 SHALL have port id_ins  output  XLEN  instruction of head entry.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL drive i_addr = fetch_pc combinationally; ce=1 only when count + inflight < DEPTH and redirect_valid=0.
REQ-017 SHALL advance fetch_pc by 4 on each cycle with ce=1, wrapping modulo 2^XLEN.
REQ-018 SHALL set inflight=1 in the cycle after ce=1, else 0; the cycle with inflight=1 and no kill SHALL write {fetch-time PC, i_data} at the tail.
REQ-019 SHALL have latency ce-to-id_valid of 2 cycles (registered queue write, no bypass).
REQ-020 SHALL pop the head on id_valid & id_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 SHALL present id_ins = 32'h0000_0013 (NOP), id_pc = 0 and id_valid=0 whenever the queue is empty.
REQ-022 SHALL, on redirect_valid=1: empty the queue next cycle, kill any in-flight response, load fetch_pc with redirect_pc with bits [1:0] forced to 0, and hold ce=0 that cycle.
REQ-023 SHALL treat a pop coinciding with redirect as delivered; the redirect still flushes all remaining entries.
REQ-024 SHALL keep queue contents and fetch_pc unchanged while id_ready=0 and full; no entry is overwritten or dropped.
REQ-025 SHALL sustain 1 instruction/cycle when id_ready=1 continuously and no redirect occurs.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge: fetch_pc=RESET_PC, count=0, inflight=0, kill=0, read/write pointers=0.
REQ-027 SHALL produce reset output values ce=0, id_valid=0, id_pc=0, id_ins=NOP, count=0, i_addr=RESET_PC.
REQ-028 SHALL discard any in-flight response when reset is asserted mid-operation; the first ce=1 occurs in the first cycle after rst_n rises.

Structure
REQ-029 SHALL take XLEN default, NOP encoding and RESET_PC default from the shared package riscv_pkg.
REQ-030 SHALL instantiate one sub-module, fetch_fifo (synchronous FIFO, parameters WIDTH=2*XLEN and DEPTH, with push/pop/full/empty/count); the fetch control stays in if_fetch_queue.

Verification
REQ-031 Reset, then id_ready=1 with memory returning addr^32'hA5A5_0000 -> id_valid first at cycle 3; id_pc sequence 0,4,8,C each cycle; ins matches.
REQ-032 id_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4; ce=0 with i_addr=16 held; on release, pcs 0,4,8,C,10 in order, none lost.
REQ-033 Redirect to 32'h0000_0102 while queue holds 3 entries and one is in flight -> next cycle count=0, id_valid=0; next fetch address 0x100; the in-flight response never appears.
REQ-034 Redirect coincident with a pop of pc=8 -> pc=8 consumed once; the next id_pc is the redirect target.
REQ-035 RESET_PC=32'hFFFF_FFF8, free run -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 Assert rst_n=0 for one cycle during a fetch with count=2 -> all outputs at reset values; the stale response is not enqueued.
